// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared encodings for the instruction-fetch controller.
//   FSM state encodings (2 bits) and the fixed instruction size in bytes.
package fetch_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam int INST_BYTES = 4;

endpackage

// File: rtl/fetch_ctrl_inst_buf.sv
// fetch_inst_buf: 1-entry instruction buffer between the I$ response and decode.
//   clk, reset   : clock, synchronous active-high reset (valid/data/pc -> 0)
//   clear        : drop the held entry (redirect); beats load and pop
//   load         : capture load_data/load_pc; beats a same-cycle pop
//   pop          : consumer took the entry
//   valid/data/pc: entry presented to decode; data/pc only change on load
module fetch_inst_buf #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = AWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              pop,
  input  logic [DWIDTH-1:0] load_data,
  input  logic [AWIDTH-1:0] load_pc,
  output logic              valid,
  output logic [DWIDTH-1:0] data,
  output logic [AWIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else begin
      if (clear)     valid <= 1'b0;
      else if (load) valid <= 1'b1;
      else if (pop)  valid <= 1'b0;
      if (load && !clear) begin
        data <= load_data;
        pc   <= load_pc;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC, issues one I$ read at a time and hands the
// returned instruction to decode through a 1-entry buffer. Redirects from
// execute replace the PC and discard any in-flight (stale) response.
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_redirect_valid/i_redirect_pc : taken branch/jump target (low 2 bits ignored)
//   o_icache_rq/rnw/addr, i_icache_gnt : request handshake (rq & gnt = issued)
//   i_icache_valid/i_icache_data   : response for the single outstanding request
//   o_inst_valid/o_inst/o_inst_pc, i_inst_ready : decode handshake
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              AWIDTH   = 32,
  parameter int              DWIDTH   = AWIDTH,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_redirect_valid,
  input  logic [AWIDTH-1:0] i_redirect_pc,
  output logic              o_icache_rq,
  output logic              o_icache_rnw,
  output logic [AWIDTH-1:0] o_icache_addr,
  input  logic              i_icache_gnt,
  input  logic              i_icache_valid,
  input  logic [DWIDTH-1:0] i_icache_data,
  output logic              o_inst_valid,
  output logic [DWIDTH-1:0] o_inst,
  output logic [AWIDTH-1:0] o_inst_pc,
  input  logic              i_inst_ready
);

  logic [1:0]        state, state_nxt;
  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] redir_tgt;
  logic              buf_free;
  logic              issue;
  logic              resp_take;
  logic              pop;

  // Masking (rather than slicing) keeps every redirect bit in use.
  assign redir_tgt = i_redirect_pc & ~AWIDTH'(3);

  // Buffer is free if empty or being popped this cycle; requesting only then
  // guarantees a response never finds the buffer full.
  assign pop       = o_inst_valid & i_inst_ready;
  assign buf_free  = !o_inst_valid | i_inst_ready;
  assign o_icache_rq   = (state == ST_REQ) & buf_free;
  assign o_icache_rnw  = 1'b1;
  assign o_icache_addr = fetch_pc;
  assign issue     = o_icache_rq & i_icache_gnt;
  // A response is kept only in WAIT and only if no redirect arrives with it.
  assign resp_take = (state == ST_WAIT) & i_icache_valid & !i_redirect_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_REQ;
      ST_REQ:   if (issue) state_nxt = i_redirect_valid ? ST_FLUSH : ST_WAIT;
      ST_WAIT:  if (i_icache_valid)        state_nxt = ST_REQ;
                else if (i_redirect_valid) state_nxt = ST_FLUSH;
      ST_FLUSH: if (i_icache_valid) state_nxt = ST_REQ;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (i_redirect_valid) fetch_pc <= redir_tgt;
      else if (resp_take)   fetch_pc <= fetch_pc + AWIDTH'(INST_BYTES);
    end
  end

  fetch_inst_buf #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk       (i_clk),
    .reset     (i_reset),
    .clear     (i_redirect_valid),
    .load      (resp_take),
    .pop       (pop),
    .load_data (i_icache_data),
    .load_pc   (fetch_pc),
    .valid     (o_inst_valid),
    .data      (o_inst),
    .pc        (o_inst_pc)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: RESET_PC = 0, driven through an I$ responder in cyc()
  logic        rst, redir_v, gnt, vld, ready;
  logic [31:0] redir_pc, data;
  logic        rq, rnw, inst_valid;
  logic [31:0] addr, inst, inst_pc;

  // dut1: RESET_PC = 0xFFFF_FFFC, driven by hand
  logic        rst1, redir_v1, gnt1, vld1, ready1;
  logic [31:0] redir_pc1, data1;
  logic        rq1, rnw1, inst_valid1;
  logic [31:0] addr1, inst1, inst_pc1;

  int total = 0;
  int bad   = 0;

  // responder state: response (data = ~addr) arrives lat cycles after the
  // cycle following the issue edge
  int          lat = 0;
  int          cnt = 0;
  bit          pend = 0;
  bit          iss = 0;
  logic [31:0] paddr = '0, iaddr = '0;

  fetch_ctrl #(.AWIDTH(32), .DWIDTH(32), .RESET_PC(32'h0)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_redirect_valid(redir_v), .i_redirect_pc(redir_pc),
    .o_icache_rq(rq), .o_icache_rnw(rnw), .o_icache_addr(addr), .i_icache_gnt(gnt),
    .i_icache_valid(vld), .i_icache_data(data), .o_inst_valid(inst_valid),
    .o_inst(inst), .o_inst_pc(inst_pc), .i_inst_ready(ready));

  fetch_ctrl #(.AWIDTH(32), .DWIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .i_clk(clk), .i_reset(rst1), .i_redirect_valid(redir_v1), .i_redirect_pc(redir_pc1),
    .o_icache_rq(rq1), .o_icache_rnw(rnw1), .o_icache_addr(addr1), .i_icache_gnt(gnt1),
    .i_icache_valid(vld1), .i_icache_data(data1), .o_inst_valid(inst_valid1),
    .o_inst(inst1), .o_inst_pc(inst_pc1), .i_inst_ready(ready1));

  task automatic cyc();
    @(negedge clk);
    iss   = (rq === 1'b1) && (gnt === 1'b1);
    iaddr = addr;
    @(posedge clk);
    #1;
    vld = 1'b0;
    if (iss) begin pend = 1'b1; cnt = lat; paddr = iaddr; end
    if (pend) begin
      if (cnt == 0) begin vld = 1'b1; data = ~paddr; pend = 1'b0; end
      else cnt--;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redir_v = 1'b0;
    cyc();
    rst = 1'b0; pend = 1'b0; vld = 1'b0;
  endtask

  task automatic test_reset();
    gnt = 1'b1; ready = 1'b1; lat = 0;
    do_reset();
    total++; if (rq !== 1'b0) begin bad++; $display("FAIL reset_rq got=%b want=0", rq); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", inst); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_inst_pc got=%h want=0", inst_pc); end
    total++; if (addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", addr); end
    total++; if (rnw !== 1'b1) begin bad++; $display("FAIL reset_rnw got=%b want=1", rnw); end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    gnt = 1'b1; ready = 1'b1; lat = 0;
    do_reset();
    cyc();
    total++; if (rq !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL stream_first_rq got rq=%b addr=%h want rq=1 addr=0", rq, addr); end
    for (int k = 0; k < 3; k++) begin
      pc = 32'(k * 4);
      cyc();
      total++; if (inst_valid !== 1'b0 || rq !== 1'b0) begin bad++; $display("FAIL stream_wait%0d got iv=%b rq=%b want 0 0", k, inst_valid, rq); end
      cyc();
      total++; if (inst_valid !== 1'b1 || inst_pc !== pc || inst !== ~pc) begin bad++; $display("FAIL stream_inst%0d got iv=%b pc=%h inst=%h want 1 %h %h", k, inst_valid, inst_pc, inst, pc, ~pc); end
      total++; if (rq !== 1'b1 || addr !== pc + 32'd4) begin bad++; $display("FAIL stream_rq%0d got rq=%b addr=%h want 1 %h", k, rq, addr, pc + 32'd4); end
    end
  endtask

  task automatic test_miss();
    int n_iss = 0;
    gnt = 1'b1; ready = 1'b1; lat = 19;
    do_reset();
    cyc();
    cyc();
    for (int k = 1; k <= 20; k++) begin
      total++; if (rq !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL miss_wait%0d got rq=%b iv=%b want 0 0", k, rq, inst_valid); end
      cyc();
      n_iss += int'(iss);
    end
    total++; if (n_iss != 0) begin bad++; $display("FAIL miss_extra_issue got=%0d want=0", n_iss); end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'hFFFF_FFFF) begin bad++; $display("FAIL miss_inst got iv=%b pc=%h inst=%h want 1 0 ffffffff", inst_valid, inst_pc, inst); end
    total++; if (rq !== 1'b1 || addr !== 32'h4) begin bad++; $display("FAIL miss_next_rq got rq=%b addr=%h want 1 4", rq, addr); end
  endtask

  task automatic test_backpressure();
    gnt = 1'b1; ready = 1'b0; lat = 0;
    do_reset();
    cyc(); cyc(); cyc();
    for (int k = 0; k < 10; k++) begin
      total++; if (inst_valid !== 1'b1 || inst !== 32'hFFFF_FFFF || inst_pc !== 32'h0 || rq !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got iv=%b inst=%h pc=%h rq=%b want 1 ffffffff 0 0", k, inst_valid, inst, inst_pc, rq); end
      cyc();
    end
    ready = 1'b1;
    #1;
    total++; if (rq !== 1'b1 || addr !== 32'h4) begin bad++; $display("FAIL bp_release_rq got rq=%b addr=%h want 1 4", rq, addr); end
    cyc();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL bp_popped got iv=%b want 0", inst_valid); end
  endtask

  task automatic test_redirect_wait();
    gnt = 1'b1; ready = 1'b1; lat = 5;
    do_reset();
    cyc(); cyc();
    redir_v = 1'b1; redir_pc = 32'h103;
    cyc();
    redir_v = 1'b0;
    total++; if (rq !== 1'b0 || addr !== 32'h100 || inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_flush got rq=%b addr=%h iv=%b want 0 100 0", rq, addr, inst_valid); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      total++; if (rq !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_flush%0d got rq=%b iv=%b want 0 0", k, rq, inst_valid); end
    end
    cyc();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_stale_dropped got iv=%b want 0", inst_valid); end
    total++; if (rq !== 1'b1 || addr !== 32'h100) begin bad++; $display("FAIL rdw_next_rq got rq=%b addr=%h want 1 100", rq, addr); end
    for (int k = 0; k < 7; k++) cyc();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'hFFFF_FEFF) begin bad++; $display("FAIL rdw_target_inst got iv=%b pc=%h inst=%h want 1 100 fffffeff", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_redirect_collide();
    gnt = 1'b1; ready = 1'b1; lat = 0;
    do_reset();
    cyc(); cyc();
    redir_v = 1'b1; redir_pc = 32'h200;
    cyc();
    redir_v = 1'b0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rdc_resp_dropped got iv=%b want 0", inst_valid); end
    total++; if (rq !== 1'b1 || addr !== 32'h200) begin bad++; $display("FAIL rdc_next_rq got rq=%b addr=%h want 1 200", rq, addr); end
    cyc(); cyc();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'hFFFF_FDFF) begin bad++; $display("FAIL rdc_inst got iv=%b pc=%h inst=%h want 1 200 fffffdff", inst_valid, inst_pc, inst); end
    redir_v = 1'b1; redir_pc = 32'h30E;
    cyc();
    redir_v = 1'b0;
    total++; if (inst_valid !== 1'b0 || rq !== 1'b0 || addr !== 32'h30C) begin bad++; $display("FAIL rdc_pop_clear got iv=%b rq=%b addr=%h want 0 0 30c", inst_valid, rq, addr); end
    cyc();
    total++; if (inst_valid !== 1'b0 || rq !== 1'b1 || addr !== 32'h30C) begin bad++; $display("FAIL rdc_flush_done got iv=%b rq=%b addr=%h want 0 1 30c", inst_valid, rq, addr); end
    cyc(); cyc();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h30C) begin bad++; $display("FAIL rdc_target_inst got iv=%b pc=%h want 1 30c", inst_valid, inst_pc); end
  endtask

  task automatic test_wrap_reset();
    gnt1 = 1'b1; ready1 = 1'b1; vld1 = 1'b0; rst1 = 1'b1;
    cyc();
    rst1 = 1'b0;
    total++; if (rq1 !== 1'b0 || addr1 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_reset got rq=%b addr=%h want 0 fffffffc", rq1, addr1); end
    cyc();
    total++; if (rq1 !== 1'b1 || addr1 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first_rq got rq=%b addr=%h want 1 fffffffc", rq1, addr1); end
    cyc();
    vld1 = 1'b1; data1 = 32'h0000_0013;
    cyc();
    vld1 = 1'b0;
    total++; if (inst_valid1 !== 1'b1 || inst_pc1 !== 32'hFFFF_FFFC || inst1 !== 32'h13) begin bad++; $display("FAIL wrap_inst got iv=%b pc=%h inst=%h want 1 fffffffc 13", inst_valid1, inst_pc1, inst1); end
    total++; if (rq1 !== 1'b1 || addr1 !== 32'h0) begin bad++; $display("FAIL wrap_second_addr got rq=%b addr=%h want 1 0", rq1, addr1); end
    cyc();
    rst1 = 1'b1;
    cyc();
    rst1 = 1'b0; vld1 = 1'b1; data1 = 32'hDEAD_BEEF;
    total++; if (inst_valid1 !== 1'b0 || rq1 !== 1'b0 || addr1 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_mid_reset got iv=%b rq=%b addr=%h want 0 0 fffffffc", inst_valid1, rq1, addr1); end
    cyc();
    vld1 = 1'b0;
    total++; if (inst_valid1 !== 1'b0 || rq1 !== 1'b1 || addr1 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_late_resp got iv=%b rq=%b addr=%h want 0 1 fffffffc", inst_valid1, rq1, addr1); end
  endtask

  initial begin
    rst = 1'b1; redir_v = 1'b0; redir_pc = '0; gnt = 1'b0; vld = 1'b0; data = '0; ready = 1'b1;
    rst1 = 1'b1; redir_v1 = 1'b0; redir_pc1 = '0; gnt1 = 1'b0; vld1 = 1'b0; data1 = '0; ready1 = 1'b1;
    test_reset();
    test_stream();
    test_miss();
    test_backpressure();
    test_redirect_wait();
    test_redirect_collide();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
